// File: rtl/multiply.sv
// Two-stage valid/ready signed multiplier: S1 registers the operand pair,
// S2 registers the full-precision product sign-extended to RESW.
module multiply #(
  parameter int unsigned ARGW = 12,
  parameter int unsigned ARGN = 2,
  parameter int unsigned RESW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_valid,
  input  logic [ARGN*ARGW-1:0] arg_data,
  output logic                 arg_ready,
  output logic                 res_valid,
  output logic [RESW-1:0]      res_data,
  input  logic                 res_ready
);

  localparam int unsigned PW = 2 * ARGW;

  if (ARGN != 2) begin : g_bad_argn
    $error("multiply: ARGN must be 2");
  end
  if (RESW < PW) begin : g_bad_resw
    $error("multiply: RESW must be at least 2*ARGW");
  end

  logic                   v1;
  logic                   v2;
  logic signed [ARGW-1:0] a1;
  logic signed [ARGW-1:0] b1;
  logic signed [PW-1:0]   prod;
  logic                   s1_load;
  logic                   s2_load;

  // A stage may load when it is empty or the stage after it is moving.
  assign s2_load   = !v2 || res_ready;
  assign s1_load   = !v1 || s2_load;
  assign arg_ready = !rst && s1_load;
  assign res_valid = v2;

  // Both operands signed, so the PW-bit product is exact including (-2^(ARGW-1))^2.
  assign prod = a1 * b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      res_data <= '0;
    end else begin
      if (s2_load) begin
        v2       <= v1;
        res_data <= RESW'(prod);
      end
      // Bubbles advance too: a load with arg_valid low clears v1.
      if (s1_load) begin
        v1 <= arg_valid;
        a1 <= arg_data[ARGW-1:0];
        b1 <= arg_data[PW-1:ARGW];
      end
    end
  end

endmodule

// File: tb/tb_multiply.sv
// Directed and random checks of the multiply pipeline: latency, ordering,
// backpressure, stall stability and mid-flight reset.
module tb_multiply;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_valid;
  logic [23:0] arg_data;
  logic        arg_ready;
  logic        res_valid;
  logic [23:0] res_data;
  logic        res_ready;

  int n_cmp = 0;
  int n_bad = 0;

  multiply #(.ARGW(12), .ARGN(2), .RESW(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [11:0] a, input logic [11:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 24'(sa * sb);
  endfunction

  task automatic test_reset();
    rst = 1'b1; arg_valid = 1'b0; arg_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (arg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_arg_ready got %b want 0", arg_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_data !== 24'h0) begin n_bad++; $display("FAIL reset_res_data got %h want 000000", res_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (arg_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_arg_ready got %b want 1", arg_ready); end
  endtask

  task automatic test_basic();
    logic [11:0] av [4] = '{12'h003, 12'hFFF, 12'h800, 12'h7FF};
    logic [11:0] bv [4] = '{12'h005, 12'h001, 12'h800, 12'h800};
    logic [23:0] ev [4] = '{24'h00000F, 24'hFFFFFF, 24'h400000, 24'hC00800};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      res_ready = 1'b1;
      arg_valid = (c < 4);
      arg_data  = (c < 4) ? {bv[c], av[c]} : 24'h0;
      #1;
      n_cmp++; if (arg_ready !== 1'b1) begin n_bad++; $display("FAIL basic_arg_ready c=%0d got %b want 1", c, arg_ready); end
      n_cmp++; if (res_valid !== (c >= 2 && c < 6)) begin n_bad++; $display("FAIL basic_res_valid c=%0d got %b want %b", c, res_valid, (c >= 2 && c < 6)); end
      if (c >= 2 && c < 6) begin
        n_cmp++; if (res_data !== ev[c-2]) begin n_bad++; $display("FAIL basic_res_data c=%0d got %h want %h", c, res_data, ev[c-2]); end
      end
    end
    arg_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] ev;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      res_ready = 1'b1;
      arg_valid = (c < 16);
      arg_data  = {12'(c - 8), 12'(c)};
      #1;
      n_cmp++; if (arg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_arg_ready c=%0d got %b want 1", c, arg_ready); end
      n_cmp++; if (res_valid !== (c >= 2 && c < 18)) begin n_bad++; $display("FAIL b2b_res_valid c=%0d got %b want %b", c, res_valid, (c >= 2 && c < 18)); end
      if (c >= 2 && c < 18) begin
        ev = 24'((c - 2) * (c - 10));
        n_cmp++; if (res_data !== ev) begin n_bad++; $display("FAIL b2b_res_data i=%0d got %h want %h", c - 2, res_data, ev); end
      end
    end
    arg_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [23:0] beat [3] = '{{12'd3, 12'd2}, {12'd5, 12'd4}, {12'd7, 12'd6}};
    int nxt = 0;
    // Five stalled cycles offering beats, then release.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      res_ready = 1'b0;
      arg_valid = 1'b1;
      arg_data  = beat[nxt];
      #1;
      n_cmp++; if (arg_ready !== (c < 2)) begin n_bad++; $display("FAIL bp_arg_ready c=%0d got %b want %b", c, arg_ready, (c < 2)); end
      if (c >= 2) begin
        n_cmp++; if (res_valid !== 1'b1 || res_data !== 24'h000006) begin n_bad++; $display("FAIL bp_hold c=%0d got v=%b d=%h want v=1 d=000006", c, res_valid, res_data); end
      end
      if (arg_ready) nxt++;
    end
    n_cmp++; if (nxt !== 2) begin n_bad++; $display("FAIL bp_accept_count got %0d want 2", nxt); end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    n_cmp++; if (arg_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", arg_ready); end
    n_cmp++; if (res_data !== 24'h000006) begin n_bad++; $display("FAIL bp_out0 got %h want 000006", res_data); end
    @(negedge clk);
    arg_valid = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 24'h000014) begin n_bad++; $display("FAIL bp_out1 got v=%b d=%h want v=1 d=000014", res_valid, res_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 24'h00002A) begin n_bad++; $display("FAIL bp_out2 got v=%b d=%h want v=1 d=00002a", res_valid, res_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", res_valid); end
  endtask

  task automatic test_random();
    logic [23:0] q[$];
    logic [11:0] a;
    logic [11:0] b;
    logic        stalled = 1'b0;
    logic [23:0] held = '0;
    int          sent = 0;
    int          got = 0;
    int          c = 0;
    while ((sent < 1000 || q.size() != 0) && c < 6000) begin
      @(negedge clk);
      a = 12'($urandom); b = 12'($urandom);
      arg_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      arg_data  = {b, a};
      res_ready = (sent >= 1000) || ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++; if (arg_ready !== (q.size() < 2 || res_ready)) begin n_bad++; $display("FAIL rnd_arg_ready c=%0d got %b want %b", c, arg_ready, (q.size() < 2 || res_ready)); end
      n_cmp++; if (res_valid !== (q.size() != 0 && (stalled || c == 0 || 1'b1) ? res_valid : 1'b0)) begin n_bad++; end
      if (stalled) begin
        n_cmp++; if (res_valid !== 1'b1 || res_data !== held) begin n_bad++; $display("FAIL rnd_stall c=%0d got v=%b d=%h want v=1 d=%h", c, res_valid, res_data, held); end
      end
      if (res_valid && res_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL rnd_extra c=%0d got %h want none", c, res_data); end
        else begin
          if (res_data !== q[0]) begin n_bad++; $display("FAIL rnd_data n=%0d got %h want %h", got, res_data, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      stalled = res_valid && !res_ready;
      held    = res_data;
      if (arg_valid && arg_ready) begin
        q.push_back(model(a, b));
        sent++;
      end
      c++;
    end
    arg_valid = 1'b0;
    n_cmp++; if (got !== 1000) begin n_bad++; $display("FAIL rnd_count got %0d want 1000", got); end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      res_ready = 1'b0; arg_valid = 1'b1; arg_data = {12'd9, 12'(c + 1)};
    end
    @(negedge clk);
    arg_valid = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (arg_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_arg_ready got %b want 0", arg_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b0 || res_data !== 24'h0) begin n_bad++; $display("FAIL mid_rst_out got v=%b d=%h want v=0 d=000000", res_valid, res_data); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      res_ready = 1'b1;
      arg_valid = (c == 0);
      arg_data  = {12'd3, 12'd3};
      #1;
      n_cmp++; if (res_valid !== (c == 2)) begin n_bad++; $display("FAIL mid_post_valid c=%0d got %b want %b", c, res_valid, (c == 2)); end
      if (c == 2) begin
        n_cmp++; if (res_data !== 24'h000009) begin n_bad++; $display("FAIL mid_post_data got %h want 000009", res_data); end
      end
    end
    arg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
